result_accumulator_writer: RTL and testbench
============================================

Name: result_accumulator_writer

Overview:
Consumer end of the matrix multiply datapath. Receives the product stream from the multiplier, in the order issued by the row/column fetcher: row of A outer, column of B middle, inner index innermost. Sums each group of INNER_DIM products into one dot product and writes it to the matrix C memory at row*MATRIX_C_COLUMNS+col. Signals completion after the full C matrix has been written.

Parameters:
MATRIX_C_ROWS, 8, rows of C (equals rows of A)
MATRIX_C_COLUMNS, 8, columns of C (equals columns of B)
INNER_DIM, 8, products per dot product (equals columns of A and rows of B)
MATRIX_C_MEM_DEPTH, 64, C memory depth; must be >= MATRIX_C_ROWS*MATRIX_C_COLUMNS
MATRIX_MEM_WIDTH, 32, data width of products, accumulator and C memory

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse that arms a new matrix accumulation
mult_out  in  MATRIX_MEM_WIDTH  product value, two's complement
mult_done  in  1  mult_out is valid this cycle; may be asserted on consecutive cycles
wr_address_c  out  $clog2(MATRIX_C_MEM_DEPTH)  C memory write address
wr_data_c  out  MATRIX_MEM_WIDTH  C memory write data
wr_en_c  out  1  C memory write strobe, single cycle, no backpressure
busy  out  1  accumulation in progress
done  out  1  one-cycle pulse on the final C write
results_written  out  $clog2(MATRIX_C_ROWS*MATRIX_C_COLUMNS+1)  count of C entries written since the last start
unexpected_product  out  1  sticky: mult_done was seen while not busy

Behaviour:
- Reset: all outputs 0; state IDLE; acc, k, col and row_offset cleared. Reset mid-operation abandons the partial sum, and no write is issued afterwards.
- FSM states: IDLE, ACCUM.
- IDLE -> ACCUM on start. The transition clears acc, k, col, row_offset, results_written and unexpected_product.
- start while in ACCUM is ignored.
- busy = (state == ACCUM).
- ACCUM, mult_done with k < INNER_DIM-1:
  - acc <= acc + mult_out, modulo 2^MATRIX_MEM_WIDTH.
  - k <= k+1.
- ACCUM, mult_done with k == INNER_DIM-1:
  - Next cycle: wr_data_c = acc + mult_out, wr_address_c = row_offset + col, wr_en_c = 1.
  - acc <= 0 and k <= 0 in the same edge, so a mult_done on the very next cycle starts the next sum with no bubble.
  - results_written increments with wr_en_c.
- Write latency: wr_en_c is high exactly 1 cycle after the final mult_done of a group. wr_address_c and wr_data_c hold their values until the next write.
- Index advance per write:
  - col == MATRIX_C_COLUMNS-1: col <= 0 and row_offset <= row_offset + MATRIX_C_COLUMNS.
  - Otherwise col <= col+1.
- Last write (row MATRIX_C_ROWS-1, col MATRIX_C_COLUMNS-1):
  - done = 1 in the same cycle as that wr_en_c.
  - State returns to IDLE on that edge, so busy = 0 in the done cycle.
- mult_done in IDLE: product discarded, no write, unexpected_product <= 1. The flag clears only on start or rst.
- mult_done without a following start leaves results_written unchanged.
- Widths: k is $clog2(INNER_DIM) bits, col is $clog2(MATRIX_C_COLUMNS) bits, row_offset is address width.
- INNER_DIM == 1 is legal: every mult_done produces a write.

Optional Feature:
ACC_SATURATE_EN
- Defined: each accumulation step is signed-saturating. On positive overflow the sum clamps to 2^(W-1)-1; on negative overflow it clamps to -2^(W-1). Once clamped, later adds in the same group continue from the clamped value. Adds a sticky output acc_saturated, set on any clamp, cleared on start or rst.
- Undefined: wrapping two's-complement addition, and the acc_saturated port does not exist.

Test Plan:
1. Defaults. start, then 512 back-to-back mult_done with mult_out=1 -> 64 writes of 8 at addresses 0..63 in order; done with write 64; results_written=64; busy=0 after.
2. Defaults. Products for C[2][5] = 1,2,...,8 -> wr_address_c=21, wr_data_c=36, wr_en_c exactly 1 cycle after the 8th mult_done.
3. Gapped stream: mult_done every 3rd cycle, values 5 -> each write is 40; no missed or extra writes; addresses are contiguous.
4. mult_done=1 with mult_out=7 in IDLE -> no wr_en_c; unexpected_product=1; a later start clears it.
5. rst asserted after 3 of 8 products -> all outputs 0 next cycle. A fresh start plus 8 products of 2 gives wr_data_c=16 at address 0.
6. Overflow: 8 products of 0x7FFFFFFF -> wrapping build writes 0xFFFFFFF8; ACC_SATURATE_EN build writes 0x7FFFFFFF with acc_saturated=1.

Source files
------------

// File: rtl/result_accumulator_writer_if.sv
// Handshake/bus bundle between the product source and result_accumulator_writer.
// acc_saturated exists only when ACC_SATURATE_EN is defined.
interface result_accumulator_writer_if #(
   parameter int MATRIX_C_ROWS      = 8,
   parameter int MATRIX_C_COLUMNS   = 8,
   parameter int MATRIX_C_MEM_DEPTH = 64,
   parameter int MATRIX_MEM_WIDTH   = 32
);
   localparam int AW = $clog2(MATRIX_C_MEM_DEPTH);
   localparam int CW = $clog2(MATRIX_C_ROWS * MATRIX_C_COLUMNS + 1);

   logic                        start;
   logic [MATRIX_MEM_WIDTH-1:0] mult_out;
   logic                        mult_done;
   logic [AW-1:0]               wr_address_c;
   logic [MATRIX_MEM_WIDTH-1:0] wr_data_c;
   logic                        wr_en_c;
   logic                        busy;
   logic                        done;
   logic [CW-1:0]               results_written;
   logic                        unexpected_product;
`ifdef ACC_SATURATE_EN
   logic                        acc_saturated;
`endif

   modport master (
      output start, mult_out, mult_done,
`ifdef ACC_SATURATE_EN
      input  acc_saturated,
`endif
      input  wr_address_c, wr_data_c, wr_en_c, busy, done,
      input  results_written, unexpected_product
   );

   modport slave (
      input  start, mult_out, mult_done,
`ifdef ACC_SATURATE_EN
      output acc_saturated,
`endif
      output wr_address_c, wr_data_c, wr_en_c, busy, done,
      output results_written, unexpected_product
   );
endinterface

// File: rtl/result_accumulator_writer.sv
// Sums each group of INNER_DIM products into one C entry and writes it row-major.
// Optional feature macro: ACC_SATURATE_EN (signed-saturating accumulation plus acc_saturated flag).
module result_accumulator_writer #(
   parameter int MATRIX_C_ROWS      = 8,
   parameter int MATRIX_C_COLUMNS   = 8,
   parameter int INNER_DIM          = 8,
   parameter int MATRIX_C_MEM_DEPTH = 64,
   parameter int MATRIX_MEM_WIDTH   = 32
) (
   input logic                      clk,
   input logic                      rst,
   result_accumulator_writer_if.slave bus
);
   localparam int W    = MATRIX_MEM_WIDTH;
   localparam int AW   = $clog2(MATRIX_C_MEM_DEPTH);
   localparam int CW   = $clog2(MATRIX_C_ROWS * MATRIX_C_COLUMNS + 1);
   // Degenerate dimensions of 1 still need a 1-bit counter that stays at zero.
   localparam int KW   = (INNER_DIM > 1) ? $clog2(INNER_DIM) : 1;
   localparam int COLW = (MATRIX_C_COLUMNS > 1) ? $clog2(MATRIX_C_COLUMNS) : 1;

   localparam logic [KW-1:0]   K_LAST          = KW'(INNER_DIM - 1);
   localparam logic [COLW-1:0] COL_LAST        = COLW'(MATRIX_C_COLUMNS - 1);
   localparam logic [AW-1:0]   ROW_STEP        = AW'(MATRIX_C_COLUMNS);
   localparam logic [AW-1:0]   LAST_ROW_OFFSET = AW'((MATRIX_C_ROWS - 1) * MATRIX_C_COLUMNS);

   typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [KW-1:0]   k_q, k_d;
   logic [COLW-1:0] col_q, col_d;
   logic [AW-1:0]   row_offset_q, row_offset_d;
   logic [AW-1:0]   wr_address_q, wr_address_d;
   logic [W-1:0]    wr_data_q, wr_data_d;
   logic            wr_en_q, wr_en_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [CW-1:0]   results_written_q, results_written_d;
   logic            unexpected_q, unexpected_d;
   logic [W-1:0]    sum_s;
   logic            clamp_s;

`ifdef ACC_SATURATE_EN
   logic            acc_saturated_q, acc_saturated_d;

   // Signed add that pins to the extreme representable value on overflow.
   function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] raw;
      raw = a + b;
      if ((a[W-1] == b[W-1]) && (raw[W-1] != a[W-1])) begin
         sat_add = a[W-1] ? {1'b1, 1'b1, {(W-1){1'b0}}} : {1'b1, 1'b0, {(W-1){1'b1}}};
      end else begin
         sat_add = {1'b0, raw};
      end
   endfunction

   assign {clamp_s, sum_s} = sat_add(acc_q, bus.mult_out);
   assign bus.acc_saturated = acc_saturated_q;
`else
   assign sum_s   = acc_q + bus.mult_out;
   assign clamp_s = 1'b0;
`endif

   // Next-state and next-output computation for the accumulate/write FSM.
   always_comb begin
      state_d           = state_q;
      acc_d             = acc_q;
      k_d               = k_q;
      col_d             = col_q;
      row_offset_d      = row_offset_q;
      wr_address_d      = wr_address_q;
      wr_data_d         = wr_data_q;
      wr_en_d           = 1'b0;
      busy_d            = busy_q;
      done_d            = 1'b0;
      results_written_d = results_written_q;
      unexpected_d      = unexpected_q;
`ifdef ACC_SATURATE_EN
      acc_saturated_d   = acc_saturated_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d           = ACCUM;
               busy_d            = 1'b1;
               acc_d             = {W{1'b0}};
               k_d               = {KW{1'b0}};
               col_d             = {COLW{1'b0}};
               row_offset_d      = {AW{1'b0}};
               results_written_d = {CW{1'b0}};
               unexpected_d      = 1'b0;
`ifdef ACC_SATURATE_EN
               acc_saturated_d   = 1'b0;
`endif
            end else if (bus.mult_done) begin
               unexpected_d = 1'b1;
            end else begin
               unexpected_d = unexpected_q;
            end
         end
         ACCUM: begin
            if (bus.mult_done) begin
`ifdef ACC_SATURATE_EN
               acc_saturated_d = acc_saturated_q | clamp_s;
`endif
               if (k_q == K_LAST) begin
                  // Group complete: emit the sum and restart the accumulator with no bubble.
                  wr_en_d           = 1'b1;
                  wr_data_d         = sum_s;
                  wr_address_d      = row_offset_q + AW'(col_q);
                  results_written_d = results_written_q + CW'(1);
                  acc_d             = {W{1'b0}};
                  k_d               = {KW{1'b0}};
                  if (col_q == COL_LAST) begin
                     col_d        = {COLW{1'b0}};
                     row_offset_d = row_offset_q + ROW_STEP;
                  end else begin
                     col_d = col_q + COLW'(1);
                  end
                  if ((col_q == COL_LAST) && (row_offset_q == LAST_ROW_OFFSET)) begin
                     state_d = IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ACCUM;
                  end
               end else begin
                  acc_d = sum_s;
                  k_d   = k_q + KW'(1);
               end
            end else begin
               acc_d = acc_q;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered-output flops with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         acc_q             <= {W{1'b0}};
         k_q               <= {KW{1'b0}};
         col_q             <= {COLW{1'b0}};
         row_offset_q      <= {AW{1'b0}};
         wr_address_q      <= {AW{1'b0}};
         wr_data_q         <= {W{1'b0}};
         wr_en_q           <= 1'b0;
         busy_q            <= 1'b0;
         done_q            <= 1'b0;
         results_written_q <= {CW{1'b0}};
         unexpected_q      <= 1'b0;
`ifdef ACC_SATURATE_EN
         acc_saturated_q   <= 1'b0;
`endif
      end else begin
         state_q           <= state_d;
         acc_q             <= acc_d;
         k_q               <= k_d;
         col_q             <= col_d;
         row_offset_q      <= row_offset_d;
         wr_address_q      <= wr_address_d;
         wr_data_q         <= wr_data_d;
         wr_en_q           <= wr_en_d;
         busy_q            <= busy_d;
         done_q            <= done_d;
         results_written_q <= results_written_d;
         unexpected_q      <= unexpected_d;
`ifdef ACC_SATURATE_EN
         acc_saturated_q   <= acc_saturated_d;
`endif
      end
   end

   assign bus.wr_address_c       = wr_address_q;
   assign bus.wr_data_c          = wr_data_q;
   assign bus.wr_en_c            = wr_en_q;
   assign bus.busy               = busy_q;
   assign bus.done               = done_q;
   assign bus.results_written    = results_written_q;
   assign bus.unexpected_product = unexpected_q;
endmodule

// File: tb/tb_result_accumulator_writer.sv
// Directed bench for result_accumulator_writer with hand-computed expectations.
// Covers both the wrapping build and the ACC_SATURATE_EN build.
module tb_result_accumulator_writer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [5:0]  wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   int          done_cnt = 0;
   int          done_write_idx = -1;
   logic        done_busy = 1'b0;

   always #5 clk = ~clk;

   result_accumulator_writer_if #(
      .MATRIX_C_ROWS(8), .MATRIX_C_COLUMNS(8), .MATRIX_C_MEM_DEPTH(64), .MATRIX_MEM_WIDTH(32)
   ) bus ();

   result_accumulator_writer #(
      .MATRIX_C_ROWS(8), .MATRIX_C_COLUMNS(8), .INNER_DIM(8),
      .MATRIX_C_MEM_DEPTH(64), .MATRIX_MEM_WIDTH(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   // Write/done monitor sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.wr_en_c) begin
         wr_addr_log.push_back(bus.wr_address_c);
         wr_data_log.push_back(bus.wr_data_c);
      end
      if (bus.done) begin
         done_cnt       = done_cnt + 1;
         done_write_idx = bus.wr_en_c ? wr_addr_log.size() : -1;
         done_busy      = bus.busy;
      end
   end

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr_log.delete();
      wr_data_log.delete();
      done_cnt       = 0;
      done_write_idx = -1;
      done_busy      = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send(input logic [31:0] v, input int gap);
      bus.mult_done = 1'b1;
      bus.mult_out  = v;
      tick();
      bus.mult_done = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check_value({tag, "_wr_en"}, 64'(bus.wr_en_c), 64'd0);
      check_value({tag, "_addr"}, 64'(bus.wr_address_c), 64'd0);
      check_value({tag, "_data"}, 64'(bus.wr_data_c), 64'd0);
      check_value({tag, "_busy"}, 64'(bus.busy), 64'd0);
      check_value({tag, "_done"}, 64'(bus.done), 64'd0);
      check_value({tag, "_count"}, 64'(bus.results_written), 64'd0);
      check_value({tag, "_unexp"}, 64'(bus.unexpected_product), 64'd0);
`ifdef ACC_SATURATE_EN
      check_value({tag, "_sat"}, 64'(bus.acc_saturated), 64'd0);
`endif
   endtask

   task automatic check_full_matrix(input string tag, input logic [31:0] exp_data);
      int bad;
      bad = 0;
      check_value({tag, "_writes"}, 64'(wr_addr_log.size()), 64'd64);
      for (int i = 0; i < wr_addr_log.size(); i++) begin
         if ((wr_addr_log[i] != 6'(i)) || (wr_data_log[i] != exp_data)) bad = bad + 1;
      end
      check_value({tag, "_bad_entries"}, 64'(bad), 64'd0);
      check_value({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check_value({tag, "_done_on_w64"}, 64'(done_write_idx), 64'd64);
      check_value({tag, "_busy_at_done"}, 64'(done_busy), 64'd0);
      check_value({tag, "_count"}, 64'(bus.results_written), 64'd64);
      check_value({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.mult_done = 1'b0;
      bus.mult_out  = 32'd0;

      // Reset state
      repeat (2) tick();
      rst = 1'b0;
      check_all_zero("reset");

      // 1: 512 back-to-back ones -> 64 writes of 8
      clear_log();
      pulse_start();
      check_value("t1_busy", 64'(bus.busy), 64'd1);
      for (int i = 0; i < 512; i++) send(32'd1, 0);
      check_value("t1_last_wr_en", 64'(bus.wr_en_c), 64'd1);
      check_value("t1_last_done", 64'(bus.done), 64'd1);
      repeat (3) tick();
      check_full_matrix("t1", 32'd8);

      // 2: C[2][5] from 1..8, start mid-stream ignored
      do_reset();
      clear_log();
      pulse_start();
      for (int i = 0; i < 168; i++) send(32'd0, 0);
      check_value("t2_count21", 64'(bus.results_written), 64'd21);
      pulse_start();
      check_value("t2_start_ignored_busy", 64'(bus.busy), 64'd1);
      check_value("t2_start_ignored_count", 64'(bus.results_written), 64'd21);
      for (int i = 1; i <= 7; i++) send(32'(i), 0);
      check_value("t2_no_early_wr", 64'(bus.wr_en_c), 64'd0);
      send(32'd8, 0);
      check_value("t2_wr_en", 64'(bus.wr_en_c), 64'd1);
      check_value("t2_addr", 64'(bus.wr_address_c), 64'd21);
      check_value("t2_data", 64'(bus.wr_data_c), 64'd36);
      check_value("t2_count22", 64'(bus.results_written), 64'd22);
      tick();
      check_value("t2_wr_en_single", 64'(bus.wr_en_c), 64'd0);
      check_value("t2_addr_hold", 64'(bus.wr_address_c), 64'd21);
      check_value("t2_data_hold", 64'(bus.wr_data_c), 64'd36);

      // 3: gapped stream of fives -> 64 writes of 40
      do_reset();
      clear_log();
      pulse_start();
      for (int i = 0; i < 512; i++) send(32'd5, 2);
      tick();
      check_full_matrix("t3", 32'd40);

      // 4: product while idle
      clear_log();
      bus.mult_done = 1'b1;
      bus.mult_out  = 32'd7;
      tick();
      bus.mult_done = 1'b0;
      repeat (2) tick();
      check_value("t4_no_write", 64'(wr_addr_log.size()), 64'd0);
      check_value("t4_unexp", 64'(bus.unexpected_product), 64'd1);
      check_value("t4_count_kept", 64'(bus.results_written), 64'd64);
      pulse_start();
      check_value("t4_unexp_cleared", 64'(bus.unexpected_product), 64'd0);
      check_value("t4_count_cleared", 64'(bus.results_written), 64'd0);
      check_value("t4_busy", 64'(bus.busy), 64'd1);

      // 5: reset after 3 products abandons the partial sum
      for (int i = 0; i < 3; i++) send(32'd9, 0);
      do_reset();
      check_all_zero("t5_rst");
      clear_log();
      pulse_start();
      for (int i = 0; i < 8; i++) send(32'd2, 0);
      check_value("t5_wr_en", 64'(bus.wr_en_c), 64'd1);
      check_value("t5_addr", 64'(bus.wr_address_c), 64'd0);
      check_value("t5_data", 64'(bus.wr_data_c), 64'd16);
      tick();
      check_value("t5_one_write", 64'(wr_addr_log.size()), 64'd1);

      // 6: overflow behaviour, positive then negative
      do_reset();
      pulse_start();
      for (int i = 0; i < 8; i++) send(32'h7FFF_FFFF, 0);
      check_value("t6_pos_wr_en", 64'(bus.wr_en_c), 64'd1);
`ifdef ACC_SATURATE_EN
      check_value("t6_pos_data", 64'(bus.wr_data_c), 64'h7FFF_FFFF);
      check_value("t6_sat_flag", 64'(bus.acc_saturated), 64'd1);
`else
      check_value("t6_pos_data", 64'(bus.wr_data_c), 64'hFFFF_FFF8);
`endif
      for (int i = 0; i < 8; i++) send(32'h8000_0000, 0);
      check_value("t6_neg_addr", 64'(bus.wr_address_c), 64'd1);
`ifdef ACC_SATURATE_EN
      check_value("t6_neg_data", 64'(bus.wr_data_c), 64'h8000_0000);
      do_reset();
      check_value("t6_sat_cleared", 64'(bus.acc_saturated), 64'd0);
`else
      check_value("t6_neg_data", 64'(bus.wr_data_c), 64'h0000_0000);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
